// File: rtl/dcache_tag_array.sv
// N-way set-associative tag store with an init/flush sweep and a registered tag compare.
// Optional per-way even parity over {tag, valid, dirty} is enabled by defining DCACHE_TAG_PARITY_EN.
module dcache_tag_array #(
  parameter int NUM_WAYS  = 4,
  parameter int NUM_SETS  = 256,
  parameter int TAG_WIDTH = 20
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  output logic                            busy_o,
  input  logic                            req_i,
  output logic                            gnt_o,
  input  logic                            we_i,
  input  logic [$clog2(NUM_SETS)-1:0]     addr_i,
  input  logic [NUM_WAYS-1:0]             way_en_i,
  input  logic [TAG_WIDTH-1:0]            wtag_i,
  input  logic                            wvalid_i,
  input  logic                            wdirty_i,
  input  logic [TAG_WIDTH-1:0]            cmp_tag_i,
  output logic                            rvalid_o,
  output logic [NUM_WAYS*TAG_WIDTH-1:0]   rtag_o,
  output logic [NUM_WAYS-1:0]             rvbits_o,
  output logic [NUM_WAYS-1:0]             rdirty_o,
  output logic                            hit_o,
  output logic [NUM_WAYS-1:0]             hit_way_o,
  output logic [NUM_WAYS-1:0]             parity_err_o
);

  localparam int SET_W = $clog2(NUM_SETS);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state, state_nxt;
  logic [SET_W-1:0]     sweep_cnt;
  logic                 sweep_last;

  logic [TAG_WIDTH-1:0] tag_mem [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  vld_mem [NUM_SETS];
  logic [NUM_WAYS-1:0]  drt_mem [NUM_SETS];

  logic                 rd_en_p0;
  logic [NUM_WAYS-1:0]  hit_way_p0;
  logic [NUM_WAYS-1:0]  perr_p0;

  assign sweep_last = (sweep_cnt == SET_W'(NUM_SETS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= SWEEP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush_i)    state_nxt = SWEEP;
      SWEEP:   if (sweep_last) state_nxt = IDLE;
      default:                 state_nxt = SWEEP;
    endcase
  end

  always_comb begin
    busy_o = (state == SWEEP);
    gnt_o  = req_i & (state == IDLE) & ~flush_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE) sweep_cnt <= '0;
    else                        sweep_cnt <= sweep_cnt + SET_W'(1);
  end

  // Storage: the sweep clears valid/dirty of one set per cycle, tags stay as they are.
  always_ff @(posedge clk_i) begin
    if (state == SWEEP) begin
      vld_mem[sweep_cnt] <= '0;
      drt_mem[sweep_cnt] <= '0;
    end else if (gnt_o && we_i) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (way_en_i[w]) begin
          tag_mem[addr_i][w] <= wtag_i;
          vld_mem[addr_i][w] <= wvalid_i;
          drt_mem[addr_i][w] <= wdirty_i;
        end
      end
    end
  end

`ifdef DCACHE_TAG_PARITY_EN
  logic [NUM_WAYS-1:0] par_mem [NUM_SETS];

  function automatic logic parity_f(input logic [TAG_WIDTH+1:0] d);
    return ^d;
  endfunction

  // Sweep recomputes parity from the retained tag with valid=dirty=0.
  always_ff @(posedge clk_i) begin
    if (state == SWEEP) begin
      for (int w = 0; w < NUM_WAYS; w++)
        par_mem[sweep_cnt][w] <= parity_f({tag_mem[sweep_cnt][w], 2'b00});
    end else if (gnt_o && we_i) begin
      for (int w = 0; w < NUM_WAYS; w++)
        if (way_en_i[w]) par_mem[addr_i][w] <= parity_f({wtag_i, wvalid_i, wdirty_i});
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++)
      perr_p0[w] = parity_f({tag_mem[addr_i][w], vld_mem[addr_i][w], drt_mem[addr_i][w]})
                   ^ par_mem[addr_i][w];
  end
`else
  assign perr_p0 = '0;
`endif

  assign rd_en_p0 = gnt_o & ~we_i;

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++)
      hit_way_p0[w] = vld_mem[addr_i][w] & (tag_mem[addr_i][w] == cmp_tag_i) & ~perr_p0[w];
  end

  // p0 -> p1: registered read data and compare result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o     <= 1'b0;
      hit_o        <= 1'b0;
      hit_way_o    <= '0;
      parity_err_o <= '0;
    end else begin
      rvalid_o     <= rd_en_p0;
      hit_o        <= rd_en_p0 & (|hit_way_p0);
      hit_way_o    <= rd_en_p0 ? hit_way_p0 : '0;
      parity_err_o <= rd_en_p0 ? perr_p0 : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_p0) begin
      for (int w = 0; w < NUM_WAYS; w++)
        rtag_o[w*TAG_WIDTH +: TAG_WIDTH] <= tag_mem[addr_i][w];
      rvbits_o <= vld_mem[addr_i];
      rdirty_o <= drt_mem[addr_i];
    end
  end

endmodule
